nn_layer_sequencer: RTL and testbench

Control-path sequencer for the neural-network inference top. It runs NUM_LAYERS HLS-generated layer kernels (dense, relu, ...) strictly in order. It drives each kernel's ap_ctrl_hs start/ready/done handshake and presents a single ap_ctrl_chain-style start/ready/done/idle/continue interface upward to the testbench and dataflow monitors. It also keeps a run counter, a sticky protocol-error flag and optional per-layer latency counters.

---
 rtl/nn_layer_sequencer.sv | 123 ++++++++++++
 tb/tb_nn_layer_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// In-order sequencer for NUM_LAYERS ap_ctrl_hs kernels behind an ap_ctrl_chain interface.
// Optional: define NN_SEQ_PROFILE_EN to enable per-layer latency counters on layer_cycles.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS = 6,
  parameter int CNT_W      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic                          ap_continue,
  output logic                          ap_ready,
  output logic                          ap_done,
  output logic                          ap_idle,
  output logic [NUM_LAYERS-1:0]         layer_start,
  input  logic [NUM_LAYERS-1:0]         layer_ready,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  output logic [$clog2(NUM_LAYERS):0]   cur_layer,
  output logic [CNT_W-1:0]              run_count,
  output logic                          seq_err,
  output logic [NUM_LAYERS*CNT_W-1:0]   layer_cycles
);
  localparam int LW = $clog2(NUM_LAYERS) + 1;
  localparam logic [LW-1:0] LAST = LW'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state, state_next;
  logic [LW-1:0]         idx, idx_next;
  logic [NUM_LAYERS-1:0] act_mask;
  logic                  act_done, act_ready, act_start;
  logic                  enter_layer, finish_run, multi_done, err_now;

  always_comb begin
    act_mask  = NUM_LAYERS'(1) << idx;
    act_done  = |(layer_done & act_mask);
    act_ready = |(layer_ready & act_mask);
    act_start = |(layer_start & act_mask);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    unique case (state)
      S_IDLE: if (ap_start) begin
        state_next = S_RUN;
        idx_next   = '0;
      end
      S_RUN: if (act_done) begin
        if (idx == LAST) state_next = S_DONE;
        else             idx_next   = idx + LW'(1);
      end
      S_DONE: if (ap_continue) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ap_idle   = (state == S_IDLE);
    ap_done   = (state == S_DONE);
    cur_layer = (state == S_RUN) ? idx : '0;
  end

  always_comb begin
    enter_layer = ((state == S_IDLE) && ap_start) ||
                  ((state == S_RUN) && act_done && (idx != LAST));
    finish_run  = (state == S_RUN) && act_done && (idx == LAST);
    multi_done  = |(layer_done & (layer_done - NUM_LAYERS'(1)));
    err_now     = multi_done |
                  ((state == S_RUN) ? |(layer_done & ~act_mask) : |layer_done);
  end

  // Start is dropped after the first ready/done of the active layer; done counts as ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      layer_start <= '0;
      ap_ready    <= 1'b0;
      run_count   <= '0;
      seq_err     <= 1'b0;
    end else begin
      if (enter_layer)
        layer_start <= NUM_LAYERS'(1) << idx_next;
      else if ((state == S_RUN) && (act_ready || act_done))
        layer_start <= '0;
      ap_ready <= (state == S_RUN) && (idx == '0) && act_start && (act_ready || act_done);
      if (finish_run) run_count <= run_count + CNT_W'(1);
      if (err_now) seq_err <= 1'b1;
    end
  end

`ifdef NN_SEQ_PROFILE_EN
  logic [CNT_W-1:0] lat_cnt [NUM_LAYERS];

  // Counter is loaded with 1 on entry so the start cycle is included in the latched value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) lat_cnt[i] <= '0;
      layer_cycles <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        if (enter_layer && (idx_next == LW'(i)))
          lat_cnt[i] <= CNT_W'(1);
        else if ((state == S_RUN) && (idx == LW'(i)) && !act_done && (lat_cnt[i] != '1))
          lat_cnt[i] <= lat_cnt[i] + CNT_W'(1);
        if ((state == S_RUN) && (idx == LW'(i)) && act_done)
          layer_cycles[i*CNT_W +: CNT_W] <= lat_cnt[i];
      end
    end
  end
`else
  always_comb layer_cycles = '0;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: 6-layer instance with randomized kernel latencies checked against
// schedule arithmetic, plus a 3-layer CNT_W=4 instance for zero-latency timing and run_count wrap.
`timescale 1ns/1ps
module tb_nn_layer_sequencer;
  localparam int N   = 6;
  localparam int W   = 32;
  localparam int CLW = $clog2(N) + 1;
  localparam int SN  = 3;
  localparam int SW  = 4;
  localparam int SCLW = $clog2(SN) + 1;
`ifdef NN_SEQ_PROFILE_EN
  localparam bit PROF = 1'b1;
`else
  localparam bit PROF = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1;
  logic ap_start = 1'b0, ap_continue = 1'b1;
  logic ap_ready, ap_done, ap_idle, seq_err;
  logic [N-1:0] layer_start, layer_ready, layer_done, inj = '0;
  logic [CLW-1:0] cur_layer;
  logic [W-1:0] run_count;
  logic [N*W-1:0] layer_cycles;

  logic s_ap_start = 1'b0, s_ap_continue = 1'b1;
  logic s_ap_ready, s_ap_done, s_ap_idle, s_seq_err;
  logic [SN-1:0] s_layer_start;
  logic [SCLW-1:0] s_cur_layer;
  logic [SW-1:0] s_run_count;
  logic [SN*SW-1:0] s_layer_cycles;

  int checks = 0, failures = 0;
  int lat_ready[N], lat_done[N];
  int exp_runs = 0, s_exp_runs = 0;
  bit exp_err = 1'b0;

  nn_layer_sequencer #(.NUM_LAYERS(N), .CNT_W(W)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .layer_start(layer_start), .layer_ready(layer_ready), .layer_done(layer_done),
    .cur_layer(cur_layer), .run_count(run_count), .seq_err(seq_err),
    .layer_cycles(layer_cycles)
  );

  nn_layer_sequencer #(.NUM_LAYERS(SN), .CNT_W(SW)) dut_small (
    .clock(clock), .reset(reset), .ap_start(s_ap_start), .ap_continue(s_ap_continue),
    .ap_ready(s_ap_ready), .ap_done(s_ap_done), .ap_idle(s_ap_idle),
    .layer_start(s_layer_start), .layer_ready(s_layer_start), .layer_done(s_layer_start),
    .cur_layer(s_cur_layer), .run_count(s_run_count), .seq_err(s_seq_err),
    .layer_cycles(s_layer_cycles)
  );

  // Kernel model: elapsed cycles since start; ready/done at programmed offsets (0 = same cycle).
  logic [N-1:0] busy = '0;
  int el[N];
  logic [N-1:0] krdy, kdone;

  always_comb begin
    krdy = '0;
    kdone = '0;
    for (int k = 0; k < N; k++) begin
      if (busy[k] || layer_start[k]) begin
        krdy[k]  = ((busy[k] ? el[k] : 0) == lat_ready[k]);
        kdone[k] = ((busy[k] ? el[k] : 0) == lat_done[k]);
      end
    end
  end
  assign layer_ready = krdy;
  assign layer_done  = kdone | inj;

  always @(posedge clock) begin
    for (int k = 0; k < N; k++) begin
      if (reset || kdone[k]) begin
        busy[k] <= 1'b0;
        el[k]   <= 0;
      end else if (busy[k] || layer_start[k]) begin
        busy[k] <= 1'b1;
        el[k]   <= (busy[k] ? el[k] : 0) + 1;
      end
    end
  end

  task automatic randomize_lats();
    for (int k = 0; k < N; k++) begin
      lat_done[k]  = $urandom_range(0, 4);
      lat_ready[k] = $urandom_range(0, lat_done[k]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ap_start = 1'b0; ap_continue = 1'b1; inj = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_runs = 0; s_exp_runs = 0; exp_err = 1'b0;
    @(negedge clock);
  endtask

  // Expected schedule: layer k starts at s[k] = s[k-1] + lat_done[k-1] + 1, s[0] = 1.
  task automatic run_main(input int cd, input int inj_layer, input int inj_bit, input bit hold);
    int s[N];
    int d, last, ecl;
    logic [N-1:0] els;
    logic [N*W-1:0] elc;
    bit erdy, edn, eidl;
    s[0] = 1;
    for (int k = 1; k < N; k++) s[k] = s[k-1] + lat_done[k-1] + 1;
    d = s[N-1] + lat_done[N-1] + 1;
    last = d + cd + 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clock);
      els = '0;
      ecl = 0;
      for (int k = 0; k < N; k++) begin
        if (c >= s[k] && c <= s[k] + lat_ready[k]) els[k] = 1'b1;
        if (c >= s[k] && c <= s[k] + lat_done[k]) ecl = k;
      end
      erdy = (c == 2 + lat_ready[0]);
      edn  = (c >= d && c <= d + cd);
      eidl = (c == 0 || c > d + cd);
      checks++;
      if ({layer_start, cur_layer, ap_ready, ap_done, ap_idle} !== {els, CLW'(ecl), erdy, edn, eidl}) begin
        failures++;
        $display("FAIL run_cycle c=%0d: got start=%b layer=%0d rdy=%b done=%b idle=%b, want start=%b layer=%0d rdy=%b done=%b idle=%b",
                 c, layer_start, cur_layer, ap_ready, ap_done, ap_idle, els, ecl, erdy, edn, eidl);
      end
      ap_start    = hold || (c == 0);
      ap_continue = (cd == 0) || (c >= d + cd);
      if (inj_layer >= 0) inj = (c == s[inj_layer]) ? (N'(1) << inj_bit) : '0;
      else                inj = '0;
    end
    inj = '0;
    exp_runs++;
    if (inj_layer >= 0) exp_err = 1'b1;
    checks++;
    if (run_count !== W'(exp_runs)) begin
      failures++;
      $display("FAIL run_count: got %0d want %0d", run_count, exp_runs);
    end
    checks++;
    if (seq_err !== exp_err) begin
      failures++;
      $display("FAIL seq_err: got %b want %b", seq_err, exp_err);
    end
    elc = '0;
    for (int k = 0; k < N; k++) if (PROF) elc[k*W +: W] = W'(lat_done[k] + 1);
    checks++;
    if (layer_cycles !== elc) begin
      failures++;
      $display("FAIL layer_cycles: got %h want %h", layer_cycles, elc);
    end
    ap_continue = 1'b1;
  endtask

  task automatic run_small();
    logic [SN-1:0] els, one;
    logic [SN*SW-1:0] elc;
    int ecl;
    one = SN'(1);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      els = (c >= 1 && c <= 3) ? (one << (c - 1)) : '0;
      ecl = (c >= 1 && c <= 3) ? c - 1 : 0;
      checks++;
      if ({s_layer_start, s_cur_layer, s_ap_ready, s_ap_done, s_ap_idle} !==
          {els, SCLW'(ecl), c == 2, c == 4, (c == 0 || c == 5)}) begin
        failures++;
        $display("FAIL small_cycle c=%0d: got start=%b layer=%0d rdy=%b done=%b idle=%b, want start=%b layer=%0d",
                 c, s_layer_start, s_cur_layer, s_ap_ready, s_ap_done, s_ap_idle, els, ecl);
      end
      s_ap_start = (c == 0);
    end
    s_exp_runs++;
    elc = PROF ? {SN{SW'(1)}} : '0;
    checks++;
    if (s_run_count !== SW'(s_exp_runs) || s_layer_cycles !== elc || s_seq_err !== 1'b0) begin
      failures++;
      $display("FAIL small_counters: got runs=%0d cyc=%h err=%b want runs=%0d cyc=%h err=0",
               s_run_count, s_layer_cycles, s_seq_err, SW'(s_exp_runs), elc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({layer_start, ap_idle, ap_done, ap_ready, cur_layer, seq_err} !== {N'(0), 1'b1, 1'b0, 1'b0, CLW'(0), 1'b0}) begin
      failures++;
      $display("FAIL reset_ctrl: got start=%b idle=%b done=%b rdy=%b layer=%0d err=%b want 0,1,0,0,0,0",
               layer_start, ap_idle, ap_done, ap_ready, cur_layer, seq_err);
    end
    checks++;
    if (run_count !== '0 || layer_cycles !== '0 || s_run_count !== '0) begin
      failures++;
      $display("FAIL reset_counters: got runs=%0d cyc=%h small_runs=%0d want 0", run_count, layer_cycles, s_run_count);
    end
  endtask

  task automatic test_zero_latency();
    run_small();
  endtask

  task automatic test_wrap();
    while (s_exp_runs < 15) run_small();
    checks++;
    if (s_run_count !== 4'd15) begin
      failures++;
      $display("FAIL wrap_pre: got %0d want 15", s_run_count);
    end
    run_small();
    checks++;
    if (s_run_count !== 4'd0) begin
      failures++;
      $display("FAIL wrap_zero: got %0d want 0", s_run_count);
    end
    run_small();
  endtask

  task automatic test_random_runs(input int n);
    for (int r = 0; r < n; r++) begin
      randomize_lats();
      run_main($urandom_range(0, 2), -1, 0, 1'b0);
    end
  endtask

  task automatic test_layer2_profile();
    randomize_lats();
    lat_ready[2] = 1;
    lat_done[2]  = 9;
    run_main(0, -1, 0, 1'b0);
    checks++;
    if (layer_cycles[2*W +: W] !== (PROF ? W'(10) : W'(0))) begin
      failures++;
      $display("FAIL layer2_cycles: got %0d want %0d", layer_cycles[2*W +: W], PROF ? 10 : 0);
    end
  endtask

  task automatic test_inject_err();
    randomize_lats();
    run_main(0, 1, 4, 1'b0);
    randomize_lats();
    run_main(1, -1, 0, 1'b0);
  endtask

  task automatic test_continue_hold();
    randomize_lats();
    run_main(5, -1, 0, 1'b1);
    @(negedge clock);
    checks++;
    if (layer_start !== N'(1) || ap_idle !== 1'b0) begin
      failures++;
      $display("FAIL continue_restart: got start=%b idle=%b want start=000001 idle=0", layer_start, ap_idle);
    end
    do_reset();
  endtask

  task automatic test_idle_err();
    checks++;
    if (seq_err !== 1'b0) begin
      failures++;
      $display("FAIL idle_err_pre: got %b want 0", seq_err);
    end
    inj = N'(4);
    @(negedge clock);
    inj = '0;
    exp_err = 1'b1;
    @(negedge clock);
    checks++;
    if (seq_err !== 1'b1) begin
      failures++;
      $display("FAIL idle_err_sticky: got %b want 1", seq_err);
    end
    randomize_lats();
    run_main(0, -1, 0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    int n;
    for (int k = 0; k < N; k++) begin
      lat_ready[k] = 0;
      lat_done[k]  = 1;
    end
    lat_done[3] = 5;
    ap_continue = 1'b1;
    @(negedge clock);
    ap_start = 1'b1;
    @(negedge clock);
    ap_start = 1'b0;
    n = 0;
    while (cur_layer !== CLW'(3) && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (cur_layer !== CLW'(3) || layer_start !== N'(8)) begin
      failures++;
      $display("FAIL midrun_reach: got layer=%0d start=%b want layer=3 start=001000", cur_layer, layer_start);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({layer_start, ap_idle, ap_done, ap_ready, cur_layer, seq_err} !== {N'(0), 1'b1, 1'b0, 1'b0, CLW'(0), 1'b0}) begin
      failures++;
      $display("FAIL midrun_reset_ctrl: got start=%b idle=%b done=%b rdy=%b layer=%0d err=%b want 0,1,0,0,0,0",
               layer_start, ap_idle, ap_done, ap_ready, cur_layer, seq_err);
    end
    checks++;
    if (run_count !== '0 || layer_cycles !== '0) begin
      failures++;
      $display("FAIL midrun_reset_counters: got runs=%0d cyc=%h want 0", run_count, layer_cycles);
    end
    reset = 1'b0;
    exp_runs = 0; s_exp_runs = 0; exp_err = 1'b0;
    @(negedge clock);
    randomize_lats();
    run_main(0, -1, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_latency();
    test_wrap();
    test_random_runs(6);
    test_layer2_profile();
    test_inject_err();
    test_continue_hold();
    test_idle_err();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
